// File: rtl/regbus_initiator.sv
// Register-bus initiator: turns one valid/ready command into a single wen/ren
// strobe, waits up to TIMEOUT cycles for ack, then holds the response until consumed.
`timescale 1ns/1ps
module regbus_initiator #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // valid-side payload must stay stable while valid is high and ready is low.
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic [15:0] addr,
   output logic        wen,
   output logic        ren,
   output logic [31:0] wdata,
   input  logic        ack,
   input  logic [31:0] rdata,
   output logic [7:0]  timeout_cnt,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic [7:0]  tocnt_q, tocnt_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q       <= IDLE;
         write_q       <= 1'b0;
         addr_q        <= 16'h0;
         wdata_q       <= 32'h0;
         cnt_q         <= 16'h0;
         rsp_rdata_q   <= 32'h0;
         rsp_timeout_q <= 1'b0;
         tocnt_q       <= 8'h0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
         tocnt_q       <= tocnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;
      tocnt_d       = tocnt_q;
      cmd_ready     = 1'b0;
      wen           = 1'b0;
      ren           = 1'b0;
      rsp_valid     = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wen     = write_q;
            ren     = ~write_q;
            cnt_d   = 16'h0;
            state_d = WAIT;
         end
         WAIT: begin
            // ack is checked first so a late ack on the last wait cycle still wins.
            if (ack) begin
               rsp_rdata_d   = write_q ? 32'h0 : rdata;
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end else if (cnt_q == LAST_WAIT) begin
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b1;
               if (tocnt_q != 8'hFF) begin
                  tocnt_d = tocnt_q + 8'd1;
               end
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign addr        = addr_q;
   assign wdata       = wdata_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_timeout = rsp_timeout_q;
   assign timeout_cnt = tocnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/regbus_initiator.md
REGBUS_INITIATOR -- requirements
Module: regbus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of cycles to wait for ack after a strobe; legal range 1..65535.
REQ-002 clk_i  in  1  clock; all logic on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  16  target register address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-012 rsp_timeout  out  1  transaction ended without ack.
REQ-013 addr  out  16  register bus address to responder.
REQ-014 wen  out  1  write strobe, one-cycle pulse.
REQ-015 ren  out  1  read strobe, one-cycle pulse.
REQ-016 wdata  out  32  register bus write data.
REQ-017 ack  in  1  responder acknowledge.
REQ-018 rdata  in  32  responder read data, valid with ack.
REQ-019 timeout_cnt  out  8  saturating count of timed-out transactions.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE.
REQ-022 IDLE: on cmd_valid, the block SHALL latch cmd_write/cmd_addr/cmd_wdata into addr/wdata and a write flag, then go to ISSUE.
REQ-023 ISSUE: the block SHALL assert exactly one of wen (write) or ren (read) for one cycle, clear the wait counter to 0, and go to WAIT.
REQ-024 wen and ren SHALL never be high simultaneously and SHALL be 0 outside ISSUE.
REQ-025 addr and wdata SHALL hold stable from ISSUE until the FSM returns to IDLE.
REQ-026 WAIT: ack=1 SHALL capture rdata into rsp_rdata for reads (0 for writes), clear rsp_timeout, and go to RESP.
REQ-027 WAIT without ack: the counter SHALL increment; at counter == TIMEOUT-1 the FSM SHALL go to RESP with rsp_timeout=1 and rsp_rdata=0.
REQ-028 ack on the cycle the counter reaches TIMEOUT-1 SHALL take priority: a normal response, no timeout.
REQ-029 Minimum latency: command accept (edge N) -> strobe in cycle N+1 -> ack in N+2 -> rsp_valid from N+3.
REQ-030 RESP: rsp_valid=1 and rsp_rdata/rsp_timeout held until rsp_ready; on handshake, go to IDLE.
REQ-031 Back-to-back: a new command SHALL be accepted at the earliest in the cycle after the response handshake.
REQ-032 ack in IDLE, ISSUE or RESP SHALL be ignored and SHALL NOT alter any output.
REQ-033 timeout_cnt SHALL increment by one per timeout and saturate at 255.

Reset
REQ-034 While rstn_i=0, independent of clk_i: state=IDLE, wen=ren=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, counter=0, timeout_cnt=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction without any response; after release, cmd_ready=1 in the first cycle.

Verification
REQ-036 Write addr=0x0104, wdata=0x00001FFF; responder acks 1 cycle after wen -> single wen pulse, addr/wdata stable, rsp_valid with rsp_rdata=0, rsp_timeout=0.
REQ-037 Read addr=0x0110; responder acks 1 cycle after ren with rdata=0xFFFFE001 -> rsp_rdata=0xFFFFE001, rsp_timeout=0, rsp_valid 3 cycles after accept.
REQ-038 TIMEOUT=4, read with no ack -> rsp_timeout=1, rsp_rdata=0, timeout_cnt=1; ack at counter=3 in a separate run -> normal response.
REQ-039 rsp_ready held 0 for 10 cycles -> rsp_valid and data held, cmd_ready=0, stray ack pulses ignored.
REQ-040 rstn_i asserted mid-WAIT -> all outputs reset asynchronously; next command completes normally.
REQ-041 300 forced timeouts -> timeout_cnt saturates at 255.
